// File: rtl/pid_pkg.sv
// Shared definitions for the time-multiplexed PID controller: register field map,
// iteration state encoding and the saturating clip helper.
package pid_pkg;

    localparam logic [2:0] FLD_KP  = 3'd0;
    localparam logic [2:0] FLD_KI  = 3'd1;
    localparam logic [2:0] FLD_KD  = 3'd2;
    localparam logic [2:0] FLD_MIN = 3'd3;
    localparam logic [2:0] FLD_MAX = 3'd4;
    localparam logic [2:0] FLD_CLR = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_MP,
        ST_MI,
        ST_MD,
        ST_SUM
    } state_t;

    // Largest / smallest value representable in a w-bit two's-complement word.
    function automatic logic signed [63:0] lim_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] lim_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Clip a wide signed value into w-bit range; the caller truncates the result.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = lim_max(w);
        lo = lim_min(w);
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pid_mc_mul_sat.sv
// Shared gain multiplier: signed product, floor shift by the gain fraction width,
// then saturation back to the data width.
module pid_mc_mul_sat
    import pid_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int Q_BITS  = 13
) (
    input  logic signed [D_WIDTH-1:0] a,
    input  logic signed [D_WIDTH-1:0] b,
    output logic signed [D_WIDTH-1:0] y
);

    logic signed [2*D_WIDTH-1:0] prod;
    logic signed [2*D_WIDTH-1:0] shifted;

    assign prod    = a * b;
    assign shifted = prod >>> Q_BITS;
    assign y       = D_WIDTH'(sat(64'(shifted), D_WIDTH));

endmodule

// File: rtl/pid_mc.sv
// N-channel PID controller sharing one multiplier; a 6-cycle iteration per request
// with per-channel gains, output limits, anti-windup integrator and error derivative.
module pid_mc
    import pid_pkg::*;
#(
    parameter int D_WIDTH = 16,
    parameter int Q_BITS  = 13,
    parameter int N_CH    = 4,
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      write_enable,
    input  logic [D_WIDTH-1:0]        reg_addr,
    input  logic [D_WIDTH-1:0]        reg_data,
    input  logic                      iterate_enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           in_ch,
    input  logic signed [D_WIDTH-1:0] target,
    input  logic signed [D_WIDTH-1:0] measurement,
    output logic signed [D_WIDTH-1:0] out,
    output logic [CH_W-1:0]           out_ch,
    output logic                      out_valid
);

    localparam logic signed [D_WIDTH-1:0] OUT_MAX_RST = D_WIDTH'(lim_max(D_WIDTH));
    localparam logic signed [D_WIDTH-1:0] OUT_MIN_RST = D_WIDTH'(lim_min(D_WIDTH));

    // Register write decode
    logic [2:0]      wr_field;
    logic [CH_W-1:0] wr_ch;
    logic            wr_ok;
    logic            clr_now;
    logic            unused_addr;

    assign wr_field    = reg_addr[2:0];
    assign wr_ch       = reg_addr[3 +: CH_W];
    assign wr_ok       = !write_enable && (32'(wr_ch) < N_CH);
    assign clr_now     = wr_ok && (wr_field == FLD_CLR);
    assign unused_addr = ^reg_addr[D_WIDTH-1:3+CH_W];

    // Iteration state and snapshot
    state_t                    state_reg;
    logic [CH_W-1:0]           cur_ch_reg;
    logic signed [D_WIDTH-1:0] tgt_reg, meas_reg;
    logic signed [D_WIDTH-1:0] kp_s_reg, ki_s_reg, kd_s_reg;
    logic signed [D_WIDTH-1:0] min_s_reg, max_s_reg, integ_s_reg, eprev_s_reg;
    logic signed [D_WIDTH-1:0] e_reg, integn_reg, d_reg;
    logic signed [D_WIDTH-1:0] p_reg, i_reg, dd_reg;
    logic signed [D_WIDTH-1:0] out_reg;
    logic [CH_W-1:0]           out_ch_reg;
    logic                      out_valid_reg;
    logic                      clr_pend_reg;

    // Per-channel storage views
    logic signed [D_WIDTH-1:0] kp_arr    [N_CH];
    logic signed [D_WIDTH-1:0] ki_arr    [N_CH];
    logic signed [D_WIDTH-1:0] kd_arr    [N_CH];
    logic signed [D_WIDTH-1:0] min_arr   [N_CH];
    logic signed [D_WIDTH-1:0] max_arr   [N_CH];
    logic signed [D_WIDTH-1:0] integ_arr [N_CH];
    logic signed [D_WIDTH-1:0] eprev_arr [N_CH];

    logic                      wb_en;
    logic                      wb_hold;
    logic signed [D_WIDTH-1:0] wb_integ;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic                      sel_wr;
        logic                      sel_wb;
        logic signed [D_WIDTH-1:0] kp_reg, ki_reg, kd_reg, min_reg, max_reg;
        logic signed [D_WIDTH-1:0] integ_reg, eprev_reg;

        assign sel_wr = wr_ok && (32'(wr_ch) == gi);
        assign sel_wb = wb_en && (32'(cur_ch_reg) == gi);

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                kp_reg    <= '0;
                ki_reg    <= '0;
                kd_reg    <= '0;
                min_reg   <= OUT_MIN_RST;
                max_reg   <= OUT_MAX_RST;
                integ_reg <= '0;
                eprev_reg <= '0;
            end else begin
                if (sel_wr) begin
                    case (wr_field)
                        FLD_KP:  kp_reg  <= reg_data;
                        FLD_KI:  ki_reg  <= reg_data;
                        FLD_KD:  kd_reg  <= reg_data;
                        FLD_MIN: min_reg <= reg_data;
                        FLD_MAX: max_reg <= reg_data;
                        default: ;
                    endcase
                end
                // A clear landing on the same edge as writeback must win.
                if (sel_wr && wr_field == FLD_CLR) begin
                    integ_reg <= '0;
                    eprev_reg <= '0;
                end else if (sel_wb) begin
                    integ_reg <= wb_integ;
                    eprev_reg <= e_reg;
                end
            end
        end

        assign kp_arr[gi]    = kp_reg;
        assign ki_arr[gi]    = ki_reg;
        assign kd_arr[gi]    = kd_reg;
        assign min_arr[gi]   = min_reg;
        assign max_arr[gi]   = max_reg;
        assign integ_arr[gi] = integ_reg;
        assign eprev_arr[gi] = eprev_reg;
    end

    // ERR stage arithmetic, one guard bit before saturation
    logic signed [D_WIDTH:0]   diff_w, acc_w, dlt_w;
    logic signed [D_WIDTH-1:0] e_next, integn_next, d_next;

    assign diff_w      = {tgt_reg[D_WIDTH-1], tgt_reg} - {meas_reg[D_WIDTH-1], meas_reg};
    assign e_next      = D_WIDTH'(sat(64'(diff_w), D_WIDTH));
    assign acc_w       = {integ_s_reg[D_WIDTH-1], integ_s_reg} + {e_next[D_WIDTH-1], e_next};
    assign integn_next = D_WIDTH'(sat(64'(acc_w), D_WIDTH));
    assign dlt_w       = {e_next[D_WIDTH-1], e_next} - {eprev_s_reg[D_WIDTH-1], eprev_s_reg};
    assign d_next      = D_WIDTH'(sat(64'(dlt_w), D_WIDTH));

    // Shared multiplier operand select
    logic signed [D_WIDTH-1:0] mul_a, mul_b, mul_y;

    always_comb begin
        mul_a = kp_s_reg;
        mul_b = e_reg;
        case (state_reg)
            ST_MI: begin
                mul_a = ki_s_reg;
                mul_b = integn_reg;
            end
            ST_MD: begin
                mul_a = kd_s_reg;
                mul_b = d_reg;
            end
            default: ;
        endcase
    end

    pid_mc_mul_sat #(
        .D_WIDTH (D_WIDTH),
        .Q_BITS  (Q_BITS)
    ) u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    // SUM stage: two extra bits hold p+i+d without overflow
    logic signed [D_WIDTH+1:0] s_w, min_ext, max_ext;
    logic signed [D_WIDTH-1:0] clamp_val;

    assign s_w     = {{2{p_reg[D_WIDTH-1]}}, p_reg} + {{2{i_reg[D_WIDTH-1]}}, i_reg}
                   + {{2{dd_reg[D_WIDTH-1]}}, dd_reg};
    assign min_ext = {{2{min_s_reg[D_WIDTH-1]}}, min_s_reg};
    assign max_ext = {{2{max_s_reg[D_WIDTH-1]}}, max_s_reg};

    always_comb begin
        clamp_val = s_w[D_WIDTH-1:0];
        if (min_s_reg > max_s_reg) begin
            clamp_val = max_s_reg;
        end else if (s_w > max_ext) begin
            clamp_val = max_s_reg;
        end else if (s_w < min_ext) begin
            clamp_val = min_s_reg;
        end
    end

    assign wb_hold  = ((s_w > max_ext) && (e_reg > 0)) || ((s_w < min_ext) && (e_reg < 0));
    assign wb_integ = wb_hold ? integ_s_reg : integn_reg;
    assign wb_en    = (state_reg == ST_SUM) && !clr_pend_reg
                    && !(clr_now && (wr_ch == cur_ch_reg));

    logic in_ch_ok;
    assign in_ch_ok = (32'(in_ch) < N_CH);
    assign in_ready = (state_reg == ST_IDLE) && iterate_enable;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg     <= ST_IDLE;
            cur_ch_reg    <= '0;
            tgt_reg       <= '0;
            meas_reg      <= '0;
            kp_s_reg      <= '0;
            ki_s_reg      <= '0;
            kd_s_reg      <= '0;
            min_s_reg     <= OUT_MIN_RST;
            max_s_reg     <= OUT_MAX_RST;
            integ_s_reg   <= '0;
            eprev_s_reg   <= '0;
            e_reg         <= '0;
            integn_reg    <= '0;
            d_reg         <= '0;
            p_reg         <= '0;
            i_reg         <= '0;
            dd_reg        <= '0;
            out_reg       <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            clr_pend_reg  <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready && in_ch_ok) begin
                        cur_ch_reg   <= in_ch;
                        tgt_reg      <= target;
                        meas_reg     <= measurement;
                        kp_s_reg     <= kp_arr[in_ch];
                        ki_s_reg     <= ki_arr[in_ch];
                        kd_s_reg     <= kd_arr[in_ch];
                        min_s_reg    <= min_arr[in_ch];
                        max_s_reg    <= max_arr[in_ch];
                        integ_s_reg  <= integ_arr[in_ch];
                        eprev_s_reg  <= eprev_arr[in_ch];
                        clr_pend_reg <= clr_now && (wr_ch == in_ch);
                        state_reg    <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    e_reg      <= e_next;
                    integn_reg <= integn_next;
                    d_reg      <= d_next;
                    state_reg  <= ST_MP;
                end
                ST_MP: begin
                    p_reg     <= mul_y;
                    state_reg <= ST_MI;
                end
                ST_MI: begin
                    i_reg     <= mul_y;
                    state_reg <= ST_MD;
                end
                ST_MD: begin
                    dd_reg    <= mul_y;
                    state_reg <= ST_SUM;
                end
                ST_SUM: begin
                    out_reg       <= clamp_val;
                    out_ch_reg    <= cur_ch_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
            if (state_reg != ST_IDLE && clr_now && wr_ch == cur_ch_reg) begin
                clr_pend_reg <= 1'b1;
            end
        end
    end

    assign out       = out_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_pid_mc.sv
// Directed bench for pid_mc: a vector table of single iterations plus hand-written
// sequences for clear, throughput, anti-windup, limits and mid-iteration reset.
module tb_pid_mc;

    logic               clk = 1'b0;
    logic               rstb;
    logic               write_enable;
    logic [15:0]        reg_addr;
    logic [15:0]        reg_data;
    logic               iterate_enable;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_ch;
    logic signed [15:0] target;
    logic signed [15:0] measurement;
    logic signed [15:0] out;
    logic [1:0]         out_ch;
    logic               out_valid;

    int checks = 0;
    int errors = 0;

    pid_mc dut (
        .clk            (clk),
        .rstb           (rstb),
        .write_enable   (write_enable),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .iterate_enable (iterate_enable),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ch          (in_ch),
        .target         (target),
        .measurement    (measurement),
        .out            (out),
        .out_ch         (out_ch),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        int         tgt;
        int         meas;
        int         exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: got %0d", name, act);
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [2:0] fld, input int data);
        @(negedge clk);
        write_enable = 1'b0;
        reg_addr     = {11'd0, ch, fld};
        reg_data     = 16'(data);
        @(negedge clk);
        write_enable = 1'b1;
    endtask

    // One iteration; clr_at=k drives a clear on ch sampled at edge T0+k (0 = none).
    task automatic run_iter(input logic [1:0] ch, input int tgt, input int meas,
                            input int exp, input string name, input int clr_at);
        int wait_n;
        int early;
        wait_n = 0;
        early  = 0;
        @(negedge clk);
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) begin
            check({name, " ready timeout"}, 0, 1);
            return;
        end
        in_valid    = 1'b1;
        in_ch       = ch;
        target      = 16'(tgt);
        measurement = 16'(meas);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (out_valid) early = 1;
        for (int k = 1; k <= 5; k++) begin
            if (k == clr_at) begin
                write_enable = 1'b0;
                reg_addr     = {11'd0, ch, 3'd7};
                reg_data     = 16'd0;
            end
            @(posedge clk);
            #1;
            if (k == clr_at) write_enable = 1'b1;
            if (k < 5 && out_valid) early = 1;
        end
        check({name, " early out_valid"}, early, 0);
        check({name, " out_valid@T0+5"}, int'(out_valid), 1);
        check({name, " out"}, int'(out), exp);
        check({name, " out_ch"}, int'(out_ch), int'(ch));
    endtask

    initial begin
        int pulses;
        rstb           = 1'b0;
        write_enable   = 1'b1;
        reg_addr       = '0;
        reg_data       = '0;
        iterate_enable = 1'b1;
        in_valid       = 1'b0;
        in_ch          = '0;
        target         = '0;
        measurement    = '0;

        vecs[0]  = '{ch: 2'd0, tgt: 1000,   meas: 0,      exp: 500};
        vecs[1]  = '{ch: 2'd1, tgt: 100,    meas: 0,      exp: 100};
        vecs[2]  = '{ch: 2'd1, tgt: 100,    meas: 0,      exp: 200};
        vecs[3]  = '{ch: 2'd2, tgt: 20000,  meas: 0,      exp: 1000};
        vecs[4]  = '{ch: 2'd3, tgt: 0,      meas: 0,      exp: 0};
        vecs[5]  = '{ch: 2'd1, tgt: 100,    meas: 0,      exp: 300};
        vecs[6]  = '{ch: 2'd2, tgt: 20000,  meas: 0,      exp: 1000};
        vecs[7]  = '{ch: 2'd3, tgt: 50,     meas: 0,      exp: 50};
        vecs[8]  = '{ch: 2'd0, tgt: -1,     meas: 0,      exp: -1};
        vecs[9]  = '{ch: 2'd3, tgt: 50,     meas: 0,      exp: 0};
        vecs[10] = '{ch: 2'd0, tgt: 2000,   meas: 1000,   exp: 500};
        vecs[11] = '{ch: 2'd0, tgt: 32767,  meas: -32768, exp: 16383};
        vecs[12] = '{ch: 2'd0, tgt: -32768, meas: 32767,  exp: -16384};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        #1;
        check("reset out", int'(out), 0);
        check("reset out_ch", int'(out_ch), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset in_ready", int'(in_ready), 1);

        // Global enable low blocks acceptance entirely.
        iterate_enable = 1'b0;
        in_valid       = 1'b1;
        pulses         = 0;
        #1;
        check("disabled in_ready", int'(in_ready), 0);
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        in_valid       = 1'b0;
        iterate_enable = 1'b1;
        check("disabled pulses", pulses, 0);

        wr(2'd0, 3'd0, 4096);
        wr(2'd1, 3'd1, 8192);
        wr(2'd2, 3'd0, 16384);
        wr(2'd2, 3'd1, 8192);
        wr(2'd2, 3'd4, 1000);
        wr(2'd3, 3'd2, 8192);

        for (int i = 0; i < 13; i++) begin
            run_iter(vecs[i].ch, vecs[i].tgt, vecs[i].meas, vecs[i].exp,
                     $sformatf("vec%0d", i), 0);
        end

        // Clear restarts the ch1 integrator.
        wr(2'd1, 3'd7, 0);
        run_iter(2'd1, 100, 0, 100, "ch1 after clear", 0);

        // ch2 integrator must have stayed at zero under anti-windup.
        wr(2'd2, 3'd0, 0);
        wr(2'd2, 3'd4, 32767);
        run_iter(2'd2, 1, 0, 1, "ch2 integ held", 0);

        // Misprogrammed limits collapse to out_max.
        wr(2'd3, 3'd3, 100);
        wr(2'd3, 3'd4, 50);
        run_iter(2'd3, 50, 0, 50, "ch3 min>max", 0);

        // Clear during flight: result from snapshot, writeback suppressed.
        run_iter(2'd1, 100, 0, 200, "ch1 inflight clear", 3);
        run_iter(2'd1, 100, 0, 100, "ch1 post clear", 0);

        // in_valid held high: one result per 6 cycles, mid-flight Kp write deferred.
        @(negedge clk);
        in_valid    = 1'b1;
        in_ch       = 2'd0;
        target      = 16'sd1000;
        measurement = 16'sd0;
        pulses      = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (n == 2) begin
                write_enable = 1'b0;
                reg_addr     = {11'd0, 2'd0, 3'd0};
                reg_data     = 16'd8192;
            end
            if (n == 3) write_enable = 1'b1;
            if (out_valid) pulses++;
            if (n == 3) check("busy in_ready", int'(in_ready), 0);
            if (n == 6) begin
                check("held 1st out_valid", int'(out_valid), 1);
                check("held 1st out", int'(out), 500);
            end
            if (n == 12) begin
                check("held 2nd out_valid", int'(out_valid), 1);
                check("held 2nd out", int'(out), 1000);
            end
        end
        in_valid = 1'b0;
        check("held pulses", pulses, 2);

        // Reset asserted during SUM discards the result.
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = 2'd0;
        target   = 16'sd1000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rstb = 1'b0;
        #1;
        check("rst mid out_valid", int'(out_valid), 0);
        check("rst mid out", int'(out), 0);
        check("rst mid in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        check("rst no pulse", int'(out_valid), 0);
        @(negedge clk);
        rstb = 1'b1;

        run_iter(2'd0, 1000, 0, 0, "post-rst ch0 Kp=0", 0);
        wr(2'd2, 3'd0, 8192);
        run_iter(2'd2, 5000, 0, 5000, "post-rst ch2 out_max", 0);
        wr(2'd1, 3'd1, 8192);
        run_iter(2'd1, 7, 0, 7, "post-rst ch1 integ", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
